// File: rtl/r_type_issue_pkg.sv
// Shared types and encoding helpers for the R-type issue path.
// Maps symbolic ALU ops onto RV64 R-type instruction fields.
package r_type_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9,
        OP_ADDW = 4'd10,
        OP_SUBW = 4'd11
    } op_e;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd11;

    localparam logic [6:0] OPCODE_OP   = 7'b0110011;
    localparam logic [6:0] OPCODE_OP32 = 7'b0111011;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        op_e        op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } req_t;

    // Returns {funct7, funct3, opcode} for a legal op.
    function automatic logic [16:0] op_fields(input op_e op);
        logic [6:0] funct7;
        logic [2:0] funct3;
        logic [6:0] opcode;
        funct7 = FUNCT7_BASE;
        funct3 = 3'b000;
        opcode = OPCODE_OP;
        case (op)
            OP_SUB:  funct7 = FUNCT7_ALT;
            OP_SLL:  funct3 = 3'b001;
            OP_SLT:  funct3 = 3'b010;
            OP_SLTU: funct3 = 3'b011;
            OP_XOR:  funct3 = 3'b100;
            OP_SRL:  funct3 = 3'b101;
            OP_SRA: begin
                funct7 = FUNCT7_ALT;
                funct3 = 3'b101;
            end
            OP_OR:   funct3 = 3'b110;
            OP_AND:  funct3 = 3'b111;
            OP_ADDW: opcode = OPCODE_OP32;
            OP_SUBW: begin
                funct7 = FUNCT7_ALT;
                opcode = OPCODE_OP32;
            end
            default: ;
        endcase
        return {funct7, funct3, opcode};
    endfunction

    function automatic logic [31:0] encode_instr(input req_t req);
        logic [16:0] fields;
        fields = op_fields(req.op);
        return {fields[16:10], req.rs2, req.rs1, fields[9:7], req.rd, fields[6:0]};
    endfunction

endpackage

// File: rtl/r_type_issue_if.sv
// Request and issue/write-back signal bundle between a requester and the issuer.
interface r_type_issue_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        hold;
    logic        issue_valid;
    logic [31:0] instruction;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic        illegal_op;

    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2, hold,
        input  req_ready, issue_valid, instruction, reg_write, write_reg, illegal_op
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, hold,
        output req_ready, issue_valid, instruction, reg_write, write_reg, illegal_op
    );

endinterface

// File: rtl/r_type_issue_instr_fifo.sv
// Synchronous FIFO with registered pointers and a 0..DEPTH occupancy count.
// The head entry is read combinationally from storage.
module instr_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/r_type_issue.sv
// Buffers symbolic ALU requests, encodes them as RV64 R-type words and issues
// one per cycle, stalling on RAW hazards and strobing write-back LAT cycles later.
module r_type_issue
    import r_type_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input logic          clk,
    input logic          reset,
    r_type_issue_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    req_t          in_req;
    req_t          head_req;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          accept;
    logic          legal;
    logic          push;
    logic          pop;
    logic          hazard;

    logic          sb_valid [LAT];
    logic [4:0]    sb_rd    [LAT];

    assign bus.req_ready = (fifo_count != CW'(DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign legal         = (bus.req_op <= OP_LAST_LEGAL);
    assign push          = accept && legal && !fifo_full;

    assign in_req.op  = op_e'(bus.req_op);
    assign in_req.rd  = bus.req_rd;
    assign in_req.rs1 = bus.req_rs1;
    assign in_req.rs2 = bus.req_rs2;

    instr_fifo #(
        .WIDTH($bits(req_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_data(in_req),
        .head     (head_req),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // The exiting write-back register is deliberately excluded: the register
    // file writes on the same edge the issued instruction reads its sources.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            if (sb_valid[i] && (sb_rd[i] != 5'd0) &&
                ((sb_rd[i] == head_req.rs1) || (sb_rd[i] == head_req.rs2))) begin
                hazard = 1'b1;
            end
        end
    end

    assign pop = !fifo_empty && !bus.hold && !hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                sb_valid[i] <= 1'b0;
                sb_rd[i]    <= 5'd0;
            end
            bus.issue_valid <= 1'b0;
            bus.instruction <= 32'd0;
            bus.reg_write   <= 1'b0;
            bus.write_reg   <= 5'd0;
            bus.illegal_op  <= 1'b0;
        end else begin
            bus.issue_valid <= pop;
            bus.instruction <= pop ? encode_instr(head_req) : 32'd0;
            bus.illegal_op  <= accept && !legal;
            sb_valid[0]     <= pop;
            sb_rd[0]        <= pop ? head_req.rd : 5'd0;
            for (int i = 1; i < LAT; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
            bus.reg_write <= sb_valid[LAT-1] && (sb_rd[LAT-1] != 5'd0);
            bus.write_reg <= sb_valid[LAT-1] ? sb_rd[LAT-1] : 5'd0;
        end
    end

endmodule
